// File: rtl/golden_nonce_arbiter.sv
// Round-robin arbiter that serialises golden-nonce strobes from NUM_CORES hashcores
// through a small FIFO onto a rate-limited single-nonce output. Optional macro: GNA_DROP_COUNT_EN.
module golden_nonce_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 7
) (
    input  logic                          hash_clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          core_match,
    input  logic [32*NUM_CORES-1:0]       core_nonce,
    output logic                          rx_new_nonce,
    output logic [31:0]                   rx_golden_nonce,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef GNA_DROP_COUNT_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CNT_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    logic [NUM_CORES-1:0] r_pend;
    logic [31:0]          r_pend_nonce [NUM_CORES];
    logic [IDX_W-1:0]     r_rr_ptr;

    logic [31:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;

    state_t               r_state;
    logic [CNT_W-1:0]     r_gap_cnt;
    logic                 r_new_nonce;
    logic [31:0]          r_golden_nonce;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_grant_vld;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [IDX_W-1:0]     w_cand;
    logic                 w_hit;
    logic [NUM_CORES-1:0] w_clr;
    logic [NUM_CORES-1:0] w_drop;
    logic [NUM_CORES-1:0] w_load;
    logic                 w_push;
    logic                 w_pop;
    logic [31:0]          w_push_data;

    assign w_full      = (r_level == LW'(FIFO_DEPTH));
    assign w_empty     = (r_level == LW'(0));
    assign w_push      = w_grant_vld;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty;
    assign w_push_data = r_pend_nonce[w_grant_idx];

    // Round-robin search for the first pending core starting at the pointer.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = IDX_W'(0);
        w_cand      = IDX_W'(0);
        w_hit       = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_cand = ((int'(r_rr_ptr) + k) >= NUM_CORES) ?
                     IDX_W'(int'(r_rr_ptr) + k - NUM_CORES) :
                     IDX_W'(int'(r_rr_ptr) + k);
            w_hit       = !w_full && !w_grant_vld && r_pend[w_cand];
            w_grant_idx = w_hit ? w_cand : w_grant_idx;
            w_grant_vld = w_grant_vld | w_hit;
        end
    end

    // Per-core grant, drop and load decisions; a grant frees the slot for a same-edge re-match.
    always_comb begin
        w_clr  = {NUM_CORES{1'b0}};
        w_drop = {NUM_CORES{1'b0}};
        w_load = {NUM_CORES{1'b0}};
        for (int i = 0; i < NUM_CORES; i++) begin
            w_clr[i]  = w_grant_vld && (w_grant_idx == IDX_W'(i));
            w_drop[i] = core_match[i] && r_pend[i] && !w_clr[i];
            w_load[i] = core_match[i] && !w_drop[i];
        end
    end

    // Pending registers and round-robin pointer.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_pend   <= {NUM_CORES{1'b0}};
            r_rr_ptr <= IDX_W'(0);
            for (int i = 0; i < NUM_CORES; i++) begin
                r_pend_nonce[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_load[i]) begin
                    r_pend[i]       <= 1'b1;
                    r_pend_nonce[i] <= core_nonce[32*i +: 32];
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end else begin
                    r_pend[i] <= r_pend[i];
                end
            end
            if (w_grant_vld) begin
                r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_CORES - 1)) ? IDX_W'(0) :
                            w_grant_idx + IDX_W'(1);
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

    // FIFO storage; contents are meaningless while the level says empty, so no reset.
    always_ff @(posedge hash_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_level  <= LW'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Output FSM: pop one nonce, pulse, then hold off for GAP_CYCLES low cycles.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_gap_cnt      <= CNT_W'(0);
            r_new_nonce    <= 1'b0;
            r_golden_nonce <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_golden_nonce <= r_mem[r_rd_ptr];
                        r_new_nonce    <= 1'b1;
                        r_gap_cnt      <= CNT_W'(GAP_CYCLES);
                        r_state        <= ST_GAP;
                    end else begin
                        r_new_nonce <= 1'b0;
                    end
                end
                ST_GAP: begin
                    r_new_nonce <= 1'b0;
                    if (r_gap_cnt <= CNT_W'(1)) begin
                        r_gap_cnt <= CNT_W'(0);
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_new_nonce <= 1'b0;
                    r_gap_cnt   <= CNT_W'(0);
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_new_nonce    = r_new_nonce;
    assign rx_golden_nonce = r_golden_nonce;
    assign fifo_level      = r_level;

`ifdef GNA_DROP_COUNT_EN
    logic [15:0] r_drop_cnt;
    logic [4:0]  w_drop_num;
    logic [16:0] w_drop_sum;

    // Number of cores losing a nonce at this edge.
    always_comb begin
        w_drop_num = 5'd0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_drop_num = w_drop_num + {4'd0, w_drop[i]};
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + {12'd0, w_drop_num};

    // Saturating drop counter.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_drop_cnt <= 16'h0000;
        end else if (w_drop_sum[16]) begin
            r_drop_cnt <= 16'hFFFF;
        end else begin
            r_drop_cnt <= w_drop_sum[15:0];
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule
